// File: rtl/mul_pe_pkg.sv
// Shared definitions for the mul_pe NoC multiplier processing element:
// flit width helper, flit field positions and the controller state encoding.
package mul_pe_pkg;

  // VC_BIT and DEST_LSB are offsets above the payload (add DATA_W);
  // SINGLE_BIT and VALID_BIT are offsets above the destination field (add DATA_W+DEST_W).
  localparam int VC_BIT     = 0;
  localparam int DEST_LSB   = 1;
  localparam int SINGLE_BIT = 1;
  localparam int VALID_BIT  = 2;

  typedef enum logic [1:0] {
    COLLECT,
    COMPUTE,
    SEND
  } state_t;

  function automatic int flit_w(input int data_w, input int dest_w);
    return data_w + dest_w + 3;
  endfunction

endpackage

// File: rtl/mul_pe_pipe.sv
// STAGES-deep registered unsigned multiplier with a valid shift chain.
// Data registers only advance behind a valid, so the product holds once it exits.
module mul_pe_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  logic [STAGES-1:0]   vld;
  logic [2*DATA_W-1:0] prod_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // NOTE: the wide data registers carry no reset; flushing the valid chain is enough
  // because nothing downstream looks at a product without its valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      prod_q[0] <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    end
    for (int i = 1; i < STAGES; i++) begin
      if (vld[i-1]) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign product   = prod_q[STAGES-1];

endmodule

// File: rtl/mul_pe.sv
// NoC multiplier PE: collects operands A and B, multiplies, and fans the result
// out to NUM_DEST destinations. Define MUL_PE_SAT_EN for unsigned saturation.
module mul_pe
  import mul_pe_pkg::*;
#(
  parameter int                         DATA_W     = 64,
  parameter int                         DEST_W     = 4,
  parameter int                         NUM_DEST   = 2,
  parameter logic [NUM_DEST*DEST_W-1:0] DEST_LIST  = {4'b0110, 4'b0001},
  parameter logic [NUM_DEST-1:0]        VC_LIST    = 2'b11,
  parameter int                         MUL_STAGES = 1,
  localparam int                        FLIT_W     = flit_w(DATA_W, DEST_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_q, b_q, a_nxt, b_nxt;
  logic                have_a_q, have_b_q, have_a_nxt, have_b_nxt;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [2*DATA_W-1:0] product;
  logic                accept, pair_done, pipe_valid, send_fire, last_copy;
  logic                unused_bits;

  assign accept    = in_flit[DATA_W+DEST_W+VALID_BIT] && in_ready;
  assign send_fire = out_valid && out_ready;
  assign last_copy = (idx_q == IDX_W'(NUM_DEST - 1));

  // NOTE: every variable gets a default before the if, so no latch is inferred.
  always_comb begin
    a_nxt      = a_q;
    b_nxt      = b_q;
    have_a_nxt = have_a_q;
    have_b_nxt = have_b_q;
    if (accept) begin
      if (in_flit[DATA_W+VC_BIT]) begin
        b_nxt      = in_flit[DATA_W-1:0];
        have_b_nxt = 1'b1;
      end else begin
        a_nxt      = in_flit[DATA_W-1:0];
        have_a_nxt = 1'b1;
      end
    end
  end

  // The multiplier is fed the post-edge operands so its first stage loads on the completing edge.
  assign pair_done = accept && have_a_nxt && have_b_nxt;

  mul_pe_pipe #(
    .DATA_W (DATA_W),
    .STAGES (MUL_STAGES)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pair_done),
    .a         (a_nxt),
    .b         (b_nxt),
    .out_valid (pipe_valid),
    .product   (product)
  );

`ifdef MUL_PE_SAT_EN
  assign result_d    = (|product[2*DATA_W-1:DATA_W]) ? '1 : product[DATA_W-1:0];
  assign unused_bits = ^in_flit[DATA_W+DEST_W+SINGLE_BIT:DATA_W+DEST_LSB];
`else
  assign result_d    = product[DATA_W-1:0];
  assign unused_bits = ^{in_flit[DATA_W+DEST_W+SINGLE_BIT:DATA_W+DEST_LSB],
                         product[2*DATA_W-1:DATA_W]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (pair_done)              state_nxt = COMPUTE;
      COMPUTE: if (pipe_valid)             state_nxt = SEND;
      SEND:    if (send_fire && last_copy) state_nxt = COLLECT;
      default:                             state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    busy      = (state != COLLECT);
    out_valid = (state == SEND);
    out_flit  = '0;
    if (state == SEND) begin
      out_flit = {1'b1, 1'b1, DEST_LIST[int'(idx_q)*DEST_W +: DEST_W], VC_LIST[idx_q], result_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      if (state == SEND && send_fire && last_copy) begin
        have_a_q <= 1'b0;
        have_b_q <= 1'b0;
      end else begin
        have_a_q <= have_a_nxt;
        have_b_q <= have_b_nxt;
      end
      if (state == COMPUTE && pipe_valid) begin
        idx_q <= '0;
      end else if (send_fire) begin
        idx_q <= last_copy ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Operand and result registers are qualified by have_* and state, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_nxt;
    b_q <= b_nxt;
    if (state == COMPUTE && pipe_valid) begin
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_pe.sv
// Self-checking bench for mul_pe: default build plus a NUM_DEST=4, MUL_STAGES=3 instance.
// Expected result flits are queued at stimulus time and compared on each output handshake.
module tb_mul_pe;

  localparam int FW = 71;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_flit0, in_flit1, out_flit0, out_flit1;
  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic          out_ready0, out_ready1, busy0, busy1;

  logic [FW-1:0] q0[$];
  logic [FW-1:0] q1[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fire1  = 0;

  logic [3:0] d1_dest [4] = '{4'hC, 4'h3, 4'hA, 4'h5};
  logic       d1_vc   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  mul_pe dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit0),
    .in_ready  (in_ready0),
    .out_flit  (out_flit0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .busy      (busy0)
  );

  mul_pe #(
    .NUM_DEST   (4),
    .DEST_LIST  (16'h5A3C),
    .VC_LIST    (4'b0101),
    .MUL_STAGES (3)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit1),
    .in_ready  (in_ready1),
    .out_flit  (out_flit1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .busy      (busy1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FW-1:0] mk_op(input logic sel, input logic [63:0] val);
    return {1'b1, 1'b0, 4'h0, sel, val};
  endfunction

  function automatic logic [FW-1:0] mk_res(input logic [3:0] dest, input logic vc, input logic [63:0] val);
    return {1'b1, 1'b1, dest, vc, val};
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
`ifdef MUL_PE_SAT_EN
    if (p[127:64] != 64'd0) return '1;
`endif
    return p[63:0];
  endfunction

  task automatic expect0(input logic [63:0] val);
    q0.push_back(mk_res(4'b0001, 1'b1, val));
    q0.push_back(mk_res(4'b0110, 1'b1, val));
  endtask

  // Scoreboard: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      if (q0.size() == 0) check("dut0_spurious_out", out_valid0, 1'b0);
      else check("dut0_flit", out_flit0, q0.pop_front());
    end
    if (!rst && out_valid1 && out_ready1) begin
      n_fire1++;
      if (q1.size() == 0) check("dut1_spurious_out", out_valid1, 1'b0);
      else check("dut1_flit", out_flit1, q1.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the flit is accepted.
  task automatic put(input int d, input logic sel, input logic [63:0] val);
    int   n;
    logic rdy;
    n = 0;
    if (d == 0) in_flit0 = mk_op(sel, val);
    else        in_flit1 = mk_op(sel, val);
    forever begin
      @(negedge clk);
      rdy = (d == 0) ? in_ready0 : in_ready1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        check("put_timeout", rdy, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    if (d == 0) in_flit0 = '0;
    else        in_flit1 = '0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((d == 0) ? (q0.size() != 0 || busy0) : (q1.size() != 0 || busy1)) && n < 200);
    check((d == 0) ? "drain0" : "drain1", (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ra, rb;
    rst = 1'b1; in_flit0 = '0; in_flit1 = '0; out_ready0 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_flit", out_flit0, '0);
    check("rst_in_ready", in_ready0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_dut1_in_ready", in_ready1, 1'b1);

    // Basic fan-out with cycle-accurate latency and busy drop.
    @(posedge clk); #1 out_ready0 = 1'b1;
    expect0(64'd40);
    put(0, 1'b0, 64'd5);
    put(0, 1'b1, 64'd8);
    @(negedge clk);
    check("basic_compute_valid", out_valid0, 1'b0);
    check("basic_compute_busy", busy0, 1'b1);
    check("basic_compute_in_ready", in_ready0, 1'b0);
    @(negedge clk); check("basic_latency", out_valid0, 1'b1);
    @(negedge clk); check("basic_copy1_valid", out_valid0, 1'b1);
    @(negedge clk);
    check("basic_busy_drop", busy0, 1'b0);
    check("basic_valid_drop", out_valid0, 1'b0);

    // Order/overwrite: the third operand flit waits until COLLECT returns.
    expect0(64'd24);
    expect0(64'd45);
    @(posedge clk); #1 in_flit0 = mk_op(1'b1, 64'd8);
    @(posedge clk); #1 in_flit0 = mk_op(1'b0, 64'd3);
    @(posedge clk); #1 in_flit0 = mk_op(1'b0, 64'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("order_in_ready_low", in_ready0, 1'b0);
    end
    @(negedge clk); check("order_in_ready_back", in_ready0, 1'b1);
    @(posedge clk); #1 in_flit0 = '0;
    put(0, 1'b1, 64'd9);
    wait_idle(0);

    // Backpressure on copy 0.
    @(posedge clk); #1 out_ready0 = 1'b0;
    expect0(64'd40);
    put(0, 1'b0, 64'd5);
    put(0, 1'b1, 64'd8);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_held", out_valid0, 1'b1);
      check("bp_flit_held", out_flit0, mk_res(4'b0001, 1'b1, 64'd40));
    end
    @(posedge clk); #1 out_ready0 = 1'b1;
    wait_idle(0);

    // Reset after copy 0 is accepted: copy 1 must never appear.
    @(posedge clk); #1;
    q0.push_back(mk_res(4'b0001, 1'b1, model(64'd3, 64'd11)));
    put(0, 1'b0, 64'd3);
    put(0, 1'b1, 64'd11);
    @(negedge clk);
    @(negedge clk); check("rst_mid_copy0_valid", out_valid0, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_abort_valid", out_valid0, 1'b0);
    check("rst_abort_busy", busy0, 1'b0);
    put(0, 1'b1, 64'd7);
    @(negedge clk); check("rst_fresh_no_stale_a", busy0, 1'b0);
    expect0(64'd14);
    put(0, 1'b0, 64'd2);
    wait_idle(0);

    // Wrap / saturate and a few random operand pairs.
    @(posedge clk); #1;
    expect0(model(64'h1_0000_0000, 64'h1_0000_0000));
    put(0, 1'b0, 64'h1_0000_0000);
    put(0, 1'b1, 64'h1_0000_0000);
    expect0(model('1, '1));
    put(0, 1'b0, '1);
    put(0, 1'b1, '1);
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {32'd0, $urandom};
      expect0(model(ra, rb));
      put(0, 1'b1, rb);
      put(0, 1'b0, ra);
    end
    wait_idle(0);

    // NUM_DEST=4, MUL_STAGES=3 instance.
    @(posedge clk); #1 out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) q1.push_back(mk_res(d1_dest[i], d1_vc[i], 64'd42));
    put(1, 1'b0, 64'd6);
    put(1, 1'b1, 64'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("sweep_latency_low", out_valid1, 1'b0);
    end
    @(negedge clk); check("sweep_latency_high", out_valid1, 1'b1);
    wait_idle(1);
    check("sweep_copy_count", n_fire1, 4);

    check("final_q0_empty", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_pe.md
Name: mul_pe

Overview:
- Parametrised NoC multiplier processing element and the next generation of the fixed two-destination multiplier node.
- Collects two operand flits (A, B) from the router ejection port and computes A*B in a pipelined multiplier.
- Fans the result out as single-flit packets to a parameter-defined list of NUM_DEST destinations, each with its own VC.
- Uses valid/ready handshakes on both sides instead of a fire-and-forget ready_send pulse.

Parameters:
- DATA_W, 64: operand/result payload width.
- DEST_W, 4: destination router address width.
- NUM_DEST, 2: number of result copies sent per computation (1..16).
- DEST_LIST, {4'b0110, 4'b0001}: packed NUM_DEST*DEST_W destinations; index 0 in the LSBs, sent first.
- VC_LIST, 2'b11: packed NUM_DEST VC bits; bit i goes with destination i.
- MUL_STAGES, 1: multiplier pipeline depth (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_flit  in  FLIT_W  incoming flit; FLIT_W = DATA_W+DEST_W+3
- in_ready  out  1  PE can accept an operand this cycle
- out_flit  out  FLIT_W  result flit to router injection port
- out_valid  out  1  out_flit valid (successor of ready_send)
- out_ready  in  1  router accepts out_flit this cycle
- busy  out  1  high in COMPUTE or SEND

Behaviour:
- Flit fields: [FLIT_W-1] valid; [FLIT_W-2] single-flit marker; [DATA_W+DEST_W:DATA_W+1] dest; [DATA_W] vc/operand-select; [DATA_W-1:0] payload.
- Input accept: in_flit[FLIT_W-1] && in_ready at the clock edge.
- Operand select: bit DATA_W = 0 loads A and sets have_a; bit DATA_W = 1 loads B and sets have_b.
- FSM states: COLLECT, COMPUTE, SEND. Reset state is COLLECT.
- COLLECT:
  - in_ready = 1.
  - A second flit to an already-held operand overwrites it (latest wins).
  - When an accept completes the pair (have_a && have_b after the edge), go to COMPUTE.
- COMPUTE:
  - in_ready = 0; lasts MUL_STAGES cycles.
  - Product is 2*DATA_W wide; the result is the low DATA_W bits (wrap-around).
  - Then go to SEND with idx = 0.
- SEND:
  - out_valid = 1; out_flit = {1, 1, DEST_LIST[idx], VC_LIST[idx], result}.
  - On out_valid && out_ready: idx increments.
  - After idx = NUM_DEST-1 is accepted: clear have_a/have_b, go to COLLECT; out_valid is 0 in the next cycle.
  - While out_ready = 0, out_flit and out_valid are held stable.
- Latency: with the pair completed on edge E, out_valid first goes high after edge E+MUL_STAGES. Each subsequent copy follows one cycle after the previous accept when out_ready = 1.
- Flits arriving while in_ready = 0 are not consumed; the router must hold them.
- Reset values: out_valid 0, out_flit 0, in_ready 1, busy 0, have_a/have_b 0, idx 0, pipeline flushed.
- Reset mid-COMPUTE or mid-SEND: aborts immediately. No further copies are emitted; the next operands start a fresh computation.
- busy = (state != COLLECT).

Optional Feature:
- Macro: MUL_PE_SAT_EN.
- Defined: if product[2*DATA_W-1:DATA_W] != 0, the result saturates to all ones (unsigned).
- Undefined: the result is the truncated low DATA_W bits.

Decomposition:
- Package mul_pe_pkg holds:
  - FLIT_W computation function;
  - field-position localparams (VALID_BIT, SINGLE_BIT, DEST_LSB, VC_BIT);
  - FSM state enum {COLLECT, COMPUTE, SEND}.
- Sub-module mul_pe_pipe: an MUL_STAGES-deep registered unsigned multiplier with DATA_W inputs and a 2*DATA_W output. It has a valid shift chain and is flushed by rst.

Test Plan:
- Basic fan-out (defaults): A=5, then B=8, out_ready=1 → out_flit {7'b1100011, 64'd40}, then {7'b1101101, 64'd40} on consecutive cycles; busy drops after the second accept.
- Order/overwrite: B=8, A=3, A=5 sent in consecutive cycles → the pair completes after the A=3 accept, so the A=5 flit arrives while in_ready = 0. Check that A=5 is not consumed, the result is 24, in_ready stays 0 through SEND, and A=5 is accepted on return to COLLECT.
- Backpressure: out_ready=0 for 3 cycles during copy 0 → out_flit held constant {7'b1100011, 64'd40}, idx unchanged; release → both copies delivered.
- Reset mid-SEND: assert rst after copy 0 is accepted → out_valid 0 next cycle, no copy 1; new A=2, B=7 → results of 14 to both destinations.
- Wrap/saturate: A=B=2^32 → result 0 without MUL_PE_SAT_EN; 64'hFFFF_FFFF_FFFF_FFFF with it.
- Parameter sweep: NUM_DEST=4, MUL_STAGES=3 → four copies in DEST_LIST order; first out_valid 3 cycles after the completing accept.
